hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for a 5-stage in-order core. Detects RAW
//   hazards between the instruction in ID and the instructions in EX and MEM,
//   and resolves them by stalling, by bypass-select generation, or by
//   flushing. Also freezes the whole pipe while data memory is busy, tracks
//   how long that freeze lasts, and keeps saturating event counters.
//
// Ports
//   clk, rst           : clock; asynchronous active-low reset
//   fwd_en             : 1 = forwarding mode, 0 = stall-only mode
//   id_src1/id_src2    : source registers of the instruction in ID
//   id_src2_valid      : id_src2 is a real register read
//   ex_dest/ex_wb_en   : ID/EX destination register and writeback flag
//   ex_mem_r_en        : instruction in EX is a load
//   mem_dest/mem_wb_en : EX/MEM destination register and writeback flag
//   branch_taken       : branch resolved taken in EX
//   mem_busy           : data memory not ready
//   clr_cnt            : synchronous clear of counters and err_timeout
//   stall_if           : hold PC and IF/ID
//   bubble_id          : zero ID/EX
//   flush              : zero IF/ID
//   freeze             : hold every pipeline register
//   fwd_sel1/fwd_sel2  : registered EX operand select
//                        (00 regfile, 01 EX/MEM ALU, 10 MEM/WB data)
//   stall_cnt/flush_cnt/freeze_cnt : saturating event counters
//   err_timeout        : sticky, memory wait exceeded MAX_WAIT cycles
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fwd_en,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src2_valid,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              ex_wb_en,
    input  logic              ex_mem_r_en,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              clr_cnt,
    output logic              stall_if,
    output logic              bubble_id,
    output logic              flush,
    output logic              freeze,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  freeze_cnt,
    output logic              err_timeout
);

    // Wait counter only needs to reach MAX_WAIT+1; it saturates there so a
    // very long memory stall cannot wrap it back below the limit.
    localparam int WAIT_W = $clog2(MAX_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic [1:0]        sel1_q, sel1_d, sel2_q, sel2_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]  freeze_cnt_q, freeze_cnt_d;

    logic hit_ex1, hit_ex2, hit_mem1, hit_mem2;
    logic hazard;
    logic [1:0] sel1_calc, sel2_calc;

    // Register 0 is hard-wired zero, so a destination of 0 never matches.
    assign hit_ex1  = (id_src1 == ex_dest)  & ex_wb_en  & (ex_dest  != '0);
    assign hit_ex2  = (id_src2 == ex_dest)  & ex_wb_en  & (ex_dest  != '0) & id_src2_valid;
    assign hit_mem1 = (id_src1 == mem_dest) & mem_wb_en & (mem_dest != '0);
    assign hit_mem2 = (id_src2 == mem_dest) & mem_wb_en & (mem_dest != '0) & id_src2_valid;

    // With bypassing only a load in EX cannot be covered: its data is not
    // available until MEM/WB, so one bubble is required.
    assign hazard = fwd_en ? (ex_mem_r_en & (hit_ex1 | hit_ex2))
                           : (hit_ex1 | hit_ex2 | hit_mem1 | hit_mem2);

    assign freeze    = mem_busy;
    assign flush     = branch_taken & ~freeze;
    assign bubble_id = flush | (hazard & ~freeze);
    assign stall_if  = hazard & ~flush & ~freeze;

    // Youngest producer (EX) wins over the older one in MEM.
    assign sel1_calc = hit_ex1 ? SEL_EX : (hit_mem1 ? SEL_MEM : SEL_RF);
    assign sel2_calc = hit_ex2 ? SEL_EX : (hit_mem2 ? SEL_MEM : SEL_RF);

    always_comb begin
        sel1_d = sel1_q;
        sel2_d = sel2_q;
        if (!freeze) begin
            if (bubble_id || !fwd_en) begin
                sel1_d = SEL_RF;
                sel2_d = SEL_RF;
            end else begin
                sel1_d = sel1_calc;
                sel2_d = sel2_calc;
            end
        end
    end

    // Memory-wait FSM and timeout detection.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (mem_busy) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_busy) begin
                    if (wait_cnt_q != WAIT_SAT) wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_d > WAIT_LIM) err_d = 1'b1;
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
        // Clear takes precedence over a timeout detected in the same cycle.
        if (clr_cnt) err_d = 1'b0;
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d  = '0;
            flush_cnt_d  = '0;
            freeze_cnt_d = '0;
        end else begin
            if (stall_if && (stall_cnt_q != '1))   stall_cnt_d  = stall_cnt_q + 1'b1;
            if (flush && (flush_cnt_q != '1))      flush_cnt_d  = flush_cnt_q + 1'b1;
            if (freeze && (freeze_cnt_q != '1))    freeze_cnt_d = freeze_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
            sel1_q       <= SEL_RF;
            sel2_q       <= SEL_RF;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
            sel1_q       <= sel1_d;
            sel2_q       <= sel2_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign fwd_sel1    = sel1_q;
    assign fwd_sel2    = sel2_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign freeze_cnt  = freeze_cnt_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Scoreboard bench for hazard_ctrl. Every cycle the bench derives the
//   expected combinational controls and the expected post-edge register
//   state from its own reference model, pushes the registered expectation
//   into a queue, and pops/compares it once the clock edge has produced it.
//   Directed scenarios add explicit constant checks on top.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
    localparam int AW = 5;
    localparam int CW = 5;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          fwd_en, id_src2_valid, ex_wb_en, ex_mem_r_en, mem_wb_en;
    logic          branch_taken, mem_busy, clr_cnt;
    logic [AW-1:0] id_src1, id_src2, ex_dest, mem_dest;
    logic          stall_if, bubble_id, flush, freeze, err_timeout;
    logic [1:0]    fwd_sel1, fwd_sel2;
    logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;

    hazard_ctrl #(.REG_AW(AW), .CNT_W(CW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en),
        .id_src1(id_src1), .id_src2(id_src2), .id_src2_valid(id_src2_valid),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .clr_cnt(clr_cnt),
        .stall_if(stall_if), .bubble_id(bubble_id), .flush(flush), .freeze(freeze),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    s1;
        logic [1:0]    s2;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        logic [CW-1:0] zc;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    // Reference model state
    logic [1:0]    m_s1, m_s2;
    logic [CW-1:0] m_sc, m_fc, m_zc;
    logic          m_err, m_wait;
    int            m_wcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 2'b00; m_s2 = 2'b00;
        m_sc = '0; m_fc = '0; m_zc = '0;
        m_err = 1'b0; m_wait = 1'b0; m_wcnt = 0;
    endtask

    task automatic idle_inputs();
        fwd_en = 1'b1; id_src1 = '0; id_src2 = '0; id_src2_valid = 1'b0;
        ex_dest = '0; ex_wb_en = 1'b0; ex_mem_r_en = 1'b0;
        mem_dest = '0; mem_wb_en = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0; clr_cnt = 1'b0;
    endtask

    // One clock cycle: inputs are already driven (just after a rising edge).
    task automatic cycle(input string tag);
        logic h1e, h2e, h1m, h2m, haz, frz, fl, bub, st, over;
        logic [1:0] c1, c2;
        exp_t e;
        #1;
        h1e = (id_src1 == ex_dest)  && ex_wb_en  && (ex_dest  != 0);
        h2e = (id_src2 == ex_dest)  && ex_wb_en  && (ex_dest  != 0) && id_src2_valid;
        h1m = (id_src1 == mem_dest) && mem_wb_en && (mem_dest != 0);
        h2m = (id_src2 == mem_dest) && mem_wb_en && (mem_dest != 0) && id_src2_valid;
        haz = fwd_en ? (ex_mem_r_en && (h1e || h2e)) : (h1e || h2e || h1m || h2m);
        frz = mem_busy;
        fl  = branch_taken && !frz;
        bub = fl || (haz && !frz);
        st  = haz && !fl && !frz;
        chk({tag, ".freeze"},    32'(freeze),    32'(frz));
        chk({tag, ".flush"},     32'(flush),     32'(fl));
        chk({tag, ".bubble_id"}, 32'(bubble_id), 32'(bub));
        chk({tag, ".stall_if"},  32'(stall_if),  32'(st));

        c1 = h1e ? 2'b01 : (h1m ? 2'b10 : 2'b00);
        c2 = h2e ? 2'b01 : (h2m ? 2'b10 : 2'b00);
        if (!frz) begin
            if (bub || !fwd_en) begin m_s1 = 2'b00; m_s2 = 2'b00; end
            else begin m_s1 = c1; m_s2 = c2; end
        end

        over = 1'b0;
        if (!m_wait) begin
            m_wcnt = 0;
            if (mem_busy) m_wait = 1'b1;
        end else if (mem_busy) begin
            m_wcnt++;
            if (m_wcnt > MW) over = 1'b1;
        end else begin
            m_wait = 1'b0;
            m_wcnt = 0;
        end

        if (clr_cnt) begin
            m_sc = '0; m_fc = '0; m_zc = '0; m_err = 1'b0;
        end else begin
            if (st  && m_sc != '1) m_sc++;
            if (fl  && m_fc != '1) m_fc++;
            if (frz && m_zc != '1) m_zc++;
            if (over) m_err = 1'b1;
        end

        e = '{s1: m_s1, s2: m_s2, sc: m_sc, fc: m_fc, zc: m_zc, err: m_err};
        sb_q.push_back(e);
        n_txn++;
        $display("txn %0d %s: fwd=%0b s1=%0d s2=%0d ex=%0d/%0b%0b mem=%0d/%0b br=%0b busy=%0b clr=%0b -> st=%0b bub=%0b fl=%0b",
                 n_txn, tag, fwd_en, id_src1, id_src2, ex_dest, ex_wb_en, ex_mem_r_en,
                 mem_dest, mem_wb_en, branch_taken, mem_busy, clr_cnt, stall_if, bubble_id, flush);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".fwd_sel1"},    32'(fwd_sel1),    32'(e.s1));
            chk({tag, ".fwd_sel2"},    32'(fwd_sel2),    32'(e.s2));
            chk({tag, ".stall_cnt"},   32'(stall_cnt),   32'(e.sc));
            chk({tag, ".flush_cnt"},   32'(flush_cnt),   32'(e.fc));
            chk({tag, ".freeze_cnt"},  32'(freeze_cnt),  32'(e.zc));
            chk({tag, ".err_timeout"}, 32'(err_timeout), 32'(e.err));
        end
    endtask

    task automatic do_clear();
        idle_inputs();
        clr_cnt = 1'b1;
        cycle("clr");
        clr_cnt = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b0;
        #12;
        chk("rst.fwd_sel1",   32'(fwd_sel1),    32'd0);
        chk("rst.fwd_sel2",   32'(fwd_sel2),    32'd0);
        chk("rst.stall_cnt",  32'(stall_cnt),   32'd0);
        chk("rst.freeze_cnt", 32'(freeze_cnt),  32'd0);
        chk("rst.err",        32'(err_timeout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Stall-only mode, EX hit on src1
        do_clear();
        fwd_en = 1'b0; id_src1 = 5'd3; ex_dest = 5'd3; ex_wb_en = 1'b1;
        cycle("r30");
        chk("r30.stall_cnt", 32'(stall_cnt), 32'd1);

        // Forwarding, EX and MEM both hit src2: EX wins, no stall
        do_clear();
        id_src2 = 5'd5; id_src2_valid = 1'b1; ex_dest = 5'd5; ex_wb_en = 1'b1;
        mem_dest = 5'd5; mem_wb_en = 1'b1;
        cycle("r31");
        chk("r31.fwd_sel2", 32'(fwd_sel2), 32'd1);
        chk("r31.stall_cnt", 32'(stall_cnt), 32'd0);

        // Load-use: one stall, then MEM/WB select once the load advances
        do_clear();
        id_src1 = 5'd7; ex_dest = 5'd7; ex_wb_en = 1'b1; ex_mem_r_en = 1'b1;
        cycle("r32a");
        chk("r32a.stall_cnt", 32'(stall_cnt), 32'd1);
        chk("r32a.fwd_sel1",  32'(fwd_sel1),  32'd0);
        ex_dest = 5'd0; ex_wb_en = 1'b0; ex_mem_r_en = 1'b0;
        mem_dest = 5'd7; mem_wb_en = 1'b1;
        cycle("r32b");
        chk("r32b.fwd_sel1",  32'(fwd_sel1),  32'd2);
        chk("r32b.stall_cnt", 32'(stall_cnt), 32'd1);

        // Taken branch together with load-use hazard
        do_clear();
        id_src1 = 5'd6; ex_dest = 5'd6; ex_wb_en = 1'b1; ex_mem_r_en = 1'b1;
        branch_taken = 1'b1;
        cycle("r33");
        chk("r33.flush_cnt", 32'(flush_cnt), 32'd1);
        chk("r33.stall_cnt", 32'(stall_cnt), 32'd0);
        chk("r33.fwd_sel1",  32'(fwd_sel1),  32'd0);

        // Long memory freeze: selects held, timeout after 17 busy cycles
        do_clear();
        id_src1 = 5'd4; ex_dest = 5'd4; ex_wb_en = 1'b1;
        cycle("r34pre");
        chk("r34pre.fwd_sel1", 32'(fwd_sel1), 32'd1);
        mem_busy = 1'b1; ex_dest = 5'd9; branch_taken = 1'b1;
        for (int i = 0; i < 17; i++) cycle("r34busy");
        chk("r34.fwd_sel1",   32'(fwd_sel1),    32'd1);
        chk("r34.err",        32'(err_timeout), 32'd1);
        chk("r34.freeze_cnt", 32'(freeze_cnt),  32'd17);
        chk("r34.flush_cnt",  32'(flush_cnt),   32'd0);
        do_clear();
        chk("r34clr.err",        32'(err_timeout), 32'd0);
        chk("r34clr.freeze_cnt", 32'(freeze_cnt),  32'd0);

        // Register 0 never matches, both modes
        id_src1 = 5'd0; ex_dest = 5'd0; ex_wb_en = 1'b1; ex_mem_r_en = 1'b1;
        mem_dest = 5'd0; mem_wb_en = 1'b1;
        cycle("r35a");
        fwd_en = 1'b0;
        cycle("r35b");
        chk("r35.stall_cnt", 32'(stall_cnt), 32'd0);
        chk("r35.fwd_sel1",  32'(fwd_sel1),  32'd0);

        // Saturation, then clear beating a simultaneous increment
        do_clear();
        fwd_en = 1'b0; id_src1 = 5'd2; ex_dest = 5'd2; ex_wb_en = 1'b1;
        for (int i = 0; i < 35; i++) cycle("sat");
        chk("sat.stall_cnt", 32'(stall_cnt), 32'd31);
        clr_cnt = 1'b1;
        cycle("clrwin");
        clr_cnt = 1'b0;
        chk("clrwin.stall_cnt", 32'(stall_cnt), 32'd0);

        // Reset asserted mid-wait abandons it
        idle_inputs();
        mem_busy = 1'b1;
        for (int i = 0; i < 6; i++) cycle("prerst");
        rst = 1'b0;
        #2;
        chk("midrst.freeze_cnt", 32'(freeze_cnt), 32'd0);
        chk("midrst.fwd_sel1",   32'(fwd_sel1),   32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 14; i++) cycle("postrst");
        chk("postrst.err", 32'(err_timeout), 32'd0);
        mem_busy = 1'b0;
        cycle("postrst_end");

        // Random traffic on a small register set
        for (int i = 0; i < 300; i++) begin
            fwd_en        = ($urandom_range(0, 3) != 0);
            id_src1       = AW'($urandom_range(0, 3));
            id_src2       = AW'($urandom_range(0, 3));
            id_src2_valid = $urandom_range(0, 1) == 1;
            ex_dest       = AW'($urandom_range(0, 3));
            ex_wb_en      = $urandom_range(0, 1) == 1;
            ex_mem_r_en   = $urandom_range(0, 2) == 0;
            mem_dest      = AW'($urandom_range(0, 3));
            mem_wb_en     = $urandom_range(0, 1) == 1;
            branch_taken  = $urandom_range(0, 5) == 0;
            mem_busy      = $urandom_range(0, 6) == 0;
            clr_cnt       = $urandom_range(0, 40) == 0;
            cycle("rnd");
        end

        if (sb_q.size() != 0) chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
